dsp_acc_unsigned_reg_neg: RTL and testbench
===========================================

// Module: dsp_acc_unsigned_reg_neg
// PURPOSE
//  Downstream stage of the negative-edge registered unsigned DSP multiplier.
//  Consumes its 38-bit product stream and accumulates a programmable number
//  of terms into one dot-product result, with saturation and an output
//  valid/ready handshake.
//  All flops update on negedge clk, as in the rest of the negative-edge DSP family.
// PARAMETERS
//  P_W    38  product input width (20x18 unsigned multiplier output)
//  ACC_W  46  accumulator/result width; must be >= P_W
//  CNT_W  8   width of term-count input len (max 2^CNT_W-1 terms)
// PORTS
//  clk        in   1      clock; all state updates on falling edge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  start      in   1      begin a new accumulation run (sampled in IDLE/DONE)
//  len        in   CNT_W  number of products to accumulate, sampled with start
//  p_in       in   P_W    unsigned product from multiplier
//  p_valid    in   1      p_in holds a valid term this cycle
//  p_ready    out  1      block accepts terms (1 only in ACCUM)
//  acc_out    out  ACC_W  accumulated result, stable while out_valid=1
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sat        out  1      sticky: accumulation saturated during this run
//  busy       out  1      1 in ACCUM or DONE
// BEHAVIOUR
//  Reset (reset=0, any time, async): state=IDLE, acc_out=0, out_valid=0,
//   sat=0, busy=0, p_ready=0, count=0. Run in progress is discarded.
//  States: IDLE, ACCUM, DONE (registered FSM, negedge clk).
//  IDLE: start=1 & len!=0 -> ACCUM, acc<=0, sat<=0, count<=len.
//   start=1 & len==0 -> DONE with acc=0, sat=0. start=0 -> stay.
//  ACCUM: p_ready=1. Per negedge with p_valid=1: acc<=sat_add(acc,p_in),
//   count<=count-1; if count==1 -> DONE, out_valid=1 from that same edge.
//   p_valid=0 -> hold (gaps allowed, no timeout). start ignored.
//  Arithmetic: p_in zero-extended to ACC_W+1; if sum > 2^ACC_W-1 then
//   acc<=all-ones and sat<=1 (sticky to end of run); later terms keep acc
//   saturated. Defaults cannot saturate (255*(2^38-1) < 2^46).
//  DONE: out_valid=1, acc_out and sat held. out_ready=1 at negedge ->
//   IDLE, out_valid<=0; if start=1 on that same edge, new run begins
//   directly (len rules as IDLE), no idle cycle. out_ready=0 -> hold.
//  Terms presented while p_ready=0 are dropped, not buffered.
//  acc_out only changes in ACCUM or on start; p_ready is combinational of state.
//  Latency: result valid on the negedge accepting the last term.
// TESTING
//  1 reset=0 for 2 edges mid-stream -> all outputs 0, state IDLE.
//  2 start,len=3; p_in=10,20,30 contiguous -> out_valid=1, acc_out=60, sat=0.
//  3 32 random terms p_in=A*B (A 20b, B 18b $random), with p_valid gaps
//    -> acc_out equals bench sum; p_in with p_ready=0 has no effect.
//  4 ACC_W=40, len=5, p_in=2^38-1 each -> acc_out=2^40-1, sat=1; 4 terms
//    -> acc_out=2^40-4, sat=0.
//  5 reset=0 after 2 of 4 terms, release, start len=2, p_in=7,8 -> 15.
//  6 len=0 start -> out_valid, acc_out=0; out_ready+start same edge,
//    len=1, p_in=9 -> next result 9, no idle cycle between runs.

Source files
------------

// File: rtl/dsp_acc_unsigned_reg_neg.sv
// Saturating dot-product accumulator fed by the negedge unsigned DSP multiplier.
// Collects len products per run and presents the result on a valid/ready handshake.
module dsp_acc_unsigned_reg_neg #(
    parameter int unsigned P_W   = 38,
    parameter int unsigned ACC_W = 46,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic               sat_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   count_q;

    logic [ACC_W:0]     sum;
    logic               launch;

    // One guard bit above the accumulator catches overflow of a single add.
    always_comb begin
        sum = {1'b0, acc_q} + {{(ACC_W + 1 - P_W){1'b0}}, p_in};
    end

    // A new run may start from IDLE, or from DONE in the same edge the result is taken.
    always_comb begin
        launch = start && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else if (launch) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            if (len == '0) begin
                state_q     <= StDone;
                out_valid_q <= 1'b1;
                count_q     <= '0;
            end else begin
                state_q     <= StAccum;
                out_valid_q <= 1'b0;
                count_q     <= len;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StIdle;
                end
                StAccum: begin
                    if (p_valid) begin
                        if (sum[ACC_W]) begin
                            acc_q <= '1;
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= sum[ACC_W-1:0];
                        end
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        p_ready   = (state_q == StAccum);
        busy      = (state_q != StIdle);
        acc_out   = acc_q;
        sat       = sat_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_dsp_acc_unsigned_reg_neg.sv
// Bench for the saturating accumulator: a run-level model drives per-cycle checks on two
// instances (default width and a narrow 40-bit accumulator) plus literal result checks.
module tb_dsp_acc_unsigned_reg_neg;

    logic        clk = 1'b1;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [37:0] p_in;
    logic        p_valid;
    logic        out_ready;

    logic        p_ready, out_valid, sat, busy;
    logic [45:0] acc_out;
    logic        p_ready40, out_valid40, sat40, busy40;
    logic [39:0] acc_out40;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dsp_acc_unsigned_reg_neg u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    dsp_acc_unsigned_reg_neg #(.P_W(38), .ACC_W(40), .CNT_W(8)) u_dut40 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready40),
        .acc_out   (acc_out40),
        .out_valid (out_valid40),
        .out_ready (out_ready),
        .sat       (sat40),
        .busy      (busy40)
    );

    // Model per instance: terms still owed, result pending, running value and sticky sat.
    int          pend [2]  = '{0, 0};
    bit          done [2]  = '{1'b0, 1'b0};
    logic [63:0] macc [2]  = '{64'd0, 64'd0};
    bit          msat [2]  = '{1'b0, 1'b0};
    logic [63:0] mmax [2]  = '{(64'd1 << 46) - 64'd1, (64'd1 << 40) - 64'd1};

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 0;
                done[i] = 1'b0;
                macc[i] = 64'd0;
                msat[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [63:0] s;
                bit          idle;
                idle = (pend[i] == 0) && !done[i];
                if (start && (idle || (done[i] && out_ready))) begin
                    macc[i] = 64'd0;
                    msat[i] = 1'b0;
                    pend[i] = int'(len);
                    done[i] = (len == 8'd0);
                end else if (done[i]) begin
                    if (out_ready) done[i] = 1'b0;
                end else if (pend[i] > 0 && p_valid) begin
                    s = macc[i] + 64'(p_in);
                    if (s > mmax[i]) begin
                        macc[i] = mmax[i];
                        msat[i] = 1'b1;
                    end else begin
                        macc[i] = s;
                    end
                    pend[i] = pend[i] - 1;
                    if (pend[i] == 0) done[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs move on negedge; compare on the following posedge.
    always @(posedge clk) begin
        if (chk_en) begin
            chk("acc_out", 64'(acc_out), macc[0]);
            chk("out_valid", 64'(out_valid), 64'(done[0]));
            chk("sat", 64'(sat), 64'(msat[0]));
            chk("busy", 64'(busy), 64'(done[0] || pend[0] > 0));
            chk("p_ready", 64'(p_ready), 64'(!done[0] && pend[0] > 0));
            chk("acc_out40", 64'(acc_out40), macc[1]);
            chk("out_valid40", 64'(out_valid40), 64'(done[1]));
            chk("sat40", 64'(sat40), 64'(msat[1]));
            chk("busy40", 64'(busy40), 64'(done[1] || pend[1] > 0));
            chk("p_ready40", 64'(p_ready40), 64'(!done[1] && pend[1] > 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [37:0] v);
        p_valid = 1'b1;
        p_in    = v;
        step();
        p_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [63:0] bench_sum;
    logic [63:0] prod;
    logic [19:0] a;
    logic [17:0] b;
    logic [37:0] big;

    initial begin
        reset = 1'b0; start = 1'b0; len = '0; p_in = '0; p_valid = 1'b0; out_ready = 1'b0;
        big   = '1;
        step();
        chk("rst_acc", 64'(acc_out), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        step();
        reset  = 1'b1;
        chk_en = 1'b1;
        step();

        // Short contiguous run.
        start_run(8'd3);
        feed(38'd10);
        feed(38'd20);
        feed(38'd30);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_acc", 64'(acc_out), 64'd60);
        chk("t2_sat", 64'(sat), 64'd0);
        drain();

        // Random products with gaps; terms outside ACCUM must be dropped.
        p_valid = 1'b1;
        p_in    = 38'h3_ffff_0000;
        step();
        step();
        start_run(8'd32);
        bench_sum = 64'd0;
        for (int k = 0; k < 32; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                p_valid = 1'b0;
                p_in    = 38'(k * 1234567);
                step();
            end
            a         = 20'($urandom);
            b         = 18'($urandom);
            prod      = 64'(a) * 64'(b);
            bench_sum = bench_sum + prod;
            feed(prod[37:0]);
        end
        p_valid = 1'b1;
        p_in    = 38'h12345;
        step();
        step();
        p_valid = 1'b0;
        chk("t3_acc", 64'(acc_out), bench_sum);
        chk("t3_valid", 64'(out_valid), 64'd1);
        drain();

        // Saturation on the narrow instance.
        start_run(8'd5);
        for (int k = 0; k < 5; k++) feed(big);
        chk("t4_acc40_sat", 64'(acc_out40), (64'd1 << 40) - 64'd1);
        chk("t4_sat40", 64'(sat40), 64'd1);
        chk("t4_acc46", 64'(acc_out), 64'd5 * ((64'd1 << 38) - 64'd1));
        drain();
        start_run(8'd4);
        for (int k = 0; k < 4; k++) feed(big);
        chk("t4_acc40_nosat", 64'(acc_out40), (64'd1 << 40) - 64'd4);
        chk("t4_sat40_clr", 64'(sat40), 64'd0);
        drain();

        // Reset mid-run, then a fresh run.
        start_run(8'd4);
        feed(38'd100);
        feed(38'd200);
        reset = 1'b0;
        step();
        step();
        chk("t1_acc", 64'(acc_out), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_pready", 64'(p_ready), 64'd0);
        chk("t1_valid", 64'(out_valid), 64'd0);
        chk("t1_sat", 64'(sat), 64'd0);
        reset = 1'b1;
        step();
        start_run(8'd2);
        feed(38'd7);
        feed(38'd8);
        chk("t5_acc", 64'(acc_out), 64'd15);
        chk("t5_valid", 64'(out_valid), 64'd1);
        drain();

        // Zero-length run, then back-to-back start on the same edge as out_ready.
        start_run(8'd0);
        chk("t6_zero_valid", 64'(out_valid), 64'd1);
        chk("t6_zero_acc", 64'(acc_out), 64'd0);
        out_ready = 1'b1;
        start_run(8'd1);
        out_ready = 1'b0;
        chk("t6_b2b_valid", 64'(out_valid), 64'd0);
        chk("t6_b2b_pready", 64'(p_ready), 64'd1);
        feed(38'd9);
        chk("t6_acc", 64'(acc_out), 64'd9);
        chk("t6_valid", 64'(out_valid), 64'd1);
        drain();
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
